// File: rtl/seg_display_sched.sv
// Display scheduler: arbitrates three requesters for the 4-digit seven-segment display and paces scanning.
// Define SEG_FIXED_PRIO_EN for fixed priority (0 > 1 > 2); default is round-robin.
module seg_display_sched #(
    parameter int PRESCALE   = 50000,
    parameter int HOLD_TICKS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  gnt,
    output logic        busy,
    output logic [1:0]  src,
    output logic        scan_tick,
    output logic [3:0]  dgt4,
    output logic [3:0]  dgt3,
    output logic [3:0]  dgt2,
    output logic [3:0]  dgt1
);

    localparam int PW = $clog2(PRESCALE);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic {IDLE, OWN} state_t;

    logic [PW-1:0] presc_q;
    logic          tick_q;
    state_t        state_q, state_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [1:0]    src_q, src_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   disp_q, disp_d;
    logic [1:0]    winner;
    logic          grab;
    logic          expiry;
    logic [15:0]   ownerData;
    logic [15:0]   winnerData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (presc_q == PW'(PRESCALE - 1));
            presc_q <= (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
        end
    end

`ifdef SEG_FIXED_PRIO_EN
    always_comb begin
        if (req[0])      winner = 2'd0;
        else if (req[1]) winner = 2'd1;
        else             winner = 2'd2;
    end
`else
    // Last-owner pointer starts at 2 so source 0 is searched first after reset.
    logic [1:0] ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     ptr_q <= 2'd2;
        else if (grab)  ptr_q <= winner;
    end

    always_comb begin
        case (ptr_q)
            2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end
`endif

    always_comb begin
        case (src_q)
            2'd0:    ownerData = data0;
            2'd1:    ownerData = data1;
            default: ownerData = data2;
        endcase
        case (winner)
            2'd0:    winnerData = data0;
            2'd1:    winnerData = data1;
            default: winnerData = data2;
        endcase
    end

    assign expiry = tick_q && (hold_q == HW'(HOLD_TICKS - 1));

    // Expiry is checked before the owner's own req so a handover wins over a simultaneous drop.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        src_d   = src_q;
        hold_d  = hold_q;
        disp_d  = disp_q;
        grab    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) grab = 1'b1;
            end
            OWN: begin
                if (expiry) begin
                    if (req != 3'b000) begin
                        grab = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 3'b000;
                    end
                end else if (!req[src_q]) begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                end else if (tick_q) begin
                    hold_d = hold_q + HW'(1);
                    disp_d = ownerData;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grab) begin
            state_d = OWN;
            gnt_d   = 3'b001 << winner;
            src_d   = winner;
            hold_d  = '0;
            disp_d  = winnerData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            src_q   <= 2'd0;
            hold_q  <= '0;
            disp_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            src_q   <= src_d;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q == OWN);
    assign src       = src_q;
    assign scan_tick = tick_q;
    assign dgt4      = disp_q[15:12];
    assign dgt3      = disp_q[11:8];
    assign dgt2      = disp_q[7:4];
    assign dgt1      = disp_q[3:0];

endmodule

// File: tb/tb_seg_display_sched.sv
// Randomized self-checking bench for seg_display_sched against a behavioural ownership model.
// Honours SEG_FIXED_PRIO_EN the same way the design does.
module tb_seg_display_sched;

    localparam int PRESCALE   = 4;
    localparam int HOLD_TICKS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic [15:0] data2 = 16'h0000;
    logic [2:0]  gnt;
    logic        busy;
    logic [1:0]  src;
    logic        scan_tick;
    logic [3:0]  dgt4, dgt3, dgt2, dgt1;

    int checks = 0;
    int failures = 0;

    // Model state: owner index (-1 when idle), last owner for the search, ticks served so far.
    int          mOwner;
    int          mLast;
    int          mSrc;
    int          mTicksServed;
    logic [15:0] mDisp;
    logic        mTick;
    int          edgeCount;

    seg_display_sched #(.PRESCALE(PRESCALE), .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk(clk), .reset(reset), .req(req),
        .data0(data0), .data1(data1), .data2(data2),
        .gnt(gnt), .busy(busy), .src(src), .scan_tick(scan_tick),
        .dgt4(dgt4), .dgt3(dgt3), .dgt2(dgt2), .dgt1(dgt1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [15:0] dataOf(input int i);
        if (i == 0) return data0;
        if (i == 1) return data1;
        return data2;
    endfunction

    function automatic int pickSource(input logic [2:0] r, input int lastOwner);
`ifdef SEG_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (lastOwner + k) % 3;
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic resetModel();
        mOwner = -1;
        mLast = 2;
        mSrc = 0;
        mTicksServed = 0;
        mDisp = 16'h0000;
        mTick = 1'b0;
        edgeCount = 0;
    endtask

    task automatic grantTo(input int w);
        mOwner = w;
        mLast = w;
        mSrc = w;
        mTicksServed = 0;
        mDisp = dataOf(w);
    endtask

    // One clock edge of the model, using the inputs held across that edge.
    task automatic modelEdge();
        edgeCount++;
        if (mOwner < 0) begin
            if (req != 3'b000) grantTo(pickSource(req, mLast));
        end else if (mTick && (mTicksServed + 1 >= HOLD_TICKS)) begin
            if (req != 3'b000) grantTo(pickSource(req, mLast));
            else mOwner = -1;
        end else if (!req[mOwner]) begin
            mOwner = -1;
        end else if (mTick) begin
            mTicksServed++;
            mDisp = dataOf(mOwner);
        end
        mTick = (edgeCount % PRESCALE == 0);
    endtask

    task automatic compareAll();
        checkOutput("gnt", {29'd0, gnt}, (mOwner < 0) ? 32'd0 : (32'd1 << mOwner));
        checkOutput("busy", {31'd0, busy}, {31'd0, (mOwner >= 0)});
        checkOutput("src", {30'd0, src}, mSrc);
        checkOutput("scan_tick", {31'd0, scan_tick}, {31'd0, mTick});
        checkOutput("digits", {16'd0, dgt4, dgt3, dgt2, dgt1}, {16'd0, mDisp});
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic applyStimulus(input logic [2:0] r, input int n);
        req = r;
        repeat (n) stepCycle();
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        resetModel();
    endtask

    initial begin
        resetModel();
        #1;
        compareAll();
        repeat (2) @(posedge clk);
        releaseReset();

        applyStimulus(3'b000, 12);

        data0 = 16'hA5C3;
        applyStimulus(3'b001, 1);
        checkOutput("first_grant_gnt", {29'd0, gnt}, 32'd1);
        checkOutput("first_grant_digits", {16'd0, dgt4, dgt3, dgt2, dgt1}, 32'h0000A5C3);
        data0 = 16'h1234;
        applyStimulus(3'b001, 10);

        data1 = 16'hBEEF;
        data2 = 16'h7E57;
        applyStimulus(3'b111, 40);

        applyStimulus(3'b000, 2);
        applyStimulus(3'b010, 4);
        data1 = 16'h0F0F;
        applyStimulus(3'b000, 1);
        checkOutput("drop_gnt", {29'd0, gnt}, 32'd0);
        checkOutput("drop_src", {30'd0, src}, 32'd1);
        applyStimulus(3'b000, 3);

        applyStimulus(3'b111, 5);
        #2;
        reset = 1'b0;
        resetModel();
        #1;
        compareAll();
        releaseReset();
        applyStimulus(3'b100, 1);
        checkOutput("post_reset_gnt", {29'd0, gnt}, 32'd4);

`ifdef SEG_FIXED_PRIO_EN
        applyStimulus(3'b000, 2);
        applyStimulus(3'b110, 30);
        checkOutput("fixed_keep_src", {30'd0, src}, 32'd1);
        applyStimulus(3'b111, 20);
        checkOutput("fixed_preempt", {29'd0, gnt}, 32'd1);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data2 = 16'($urandom);
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
